// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin write/read front end for a single-strobe mem,
// tracking the 1-cycle read latency and buffering responses in a 2-entry FIFO.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_ADR    = 100,
   parameter int ADDRSIZE   = $clog2(MAX_ADR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDRSIZE-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rq_valid,
   output logic                  rq_ready,
   input  logic [ADDRSIZE-1:0]   rq_addr,
   output logic                  rs_valid,
   input  logic                  rs_ready,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic                  rs_err,
   output logic [7:0]            drop_cnt,
   output logic                  mem_rd_en,
   output logic [ADDRSIZE-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_wr_en,
   output logic [ADDRSIZE-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data
);
   logic [1:0]            cnt, eff;
   logic                  pending, pending_err, last_rd;
   logic [DATA_WIDTH-1:0] h_d, t_d, push_d;
   logic                  h_e, t_e;
   logic                  wr_ok, rd_ok, pop, rd_space, grant_rd, wr_fire, rd_fire;
   assign rs_valid    = cnt != 2'd0;
   assign rs_data     = h_d;
   assign rs_err      = h_e;
   assign mem_rd_addr = rq_addr;
   assign mem_wr_addr = wr_addr;
   assign mem_wr_data = wr_data;
   always_comb begin
      wr_ok    = int'(wr_addr) < MAX_ADR;
      rd_ok    = int'(rq_addr) < MAX_ADR;
      pop      = rs_valid & rs_ready;
      // a response leaving this cycle frees its slot, so back-to-back reads keep full rate
      rd_space = ({1'b0, cnt} + {2'b0, pending}) < (3'd2 + {2'b0, pop});
      grant_rd = !rst && rq_valid && rd_space && !(wr_valid && last_rd);
      rq_ready = grant_rd;
      wr_ready = !rst && !grant_rd;
      wr_fire  = wr_valid & wr_ready;
      rd_fire  = rq_valid & rq_ready;
      mem_wr_en = wr_fire & wr_ok;
      mem_rd_en = rd_fire & rd_ok;
      eff      = cnt - {1'b0, pop};
      push_d   = pending_err ? '0 : mem_rd_data;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt         <= '0;
         pending     <= 1'b0;
         pending_err <= 1'b0;
         last_rd     <= 1'b0;
         drop_cnt    <= '0;
         h_d         <= '0;
         h_e         <= 1'b0;
         t_d         <= '0;
         t_e         <= 1'b0;
      end else begin
         pending     <= rd_fire;
         pending_err <= rd_fire & ~rd_ok;
         if (wr_fire | rd_fire) last_rd <= rd_fire;
         if (wr_fire && !wr_ok && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
         if (pending && eff == 2'd0) {h_d, h_e} <= {push_d, pending_err};
         else if (pop) {h_d, h_e} <= {t_d, t_e};
         if (pending && eff == 2'd1) {t_d, t_e} <= {push_d, pending_err};
         cnt <= cnt + {1'b0, pending} - {1'b0, pop};
      end
   always_ff @(posedge clk)
      if (!rst) assert (!(pending && cnt == 2'd2));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized traffic checked against a
// transaction-level model (reference memory plus in-order response queue).
module tb_mem_port_arbiter;
   localparam int MA = 100, AW = 7;
   typedef struct {
      logic [7:0] d;
      logic       e;
      int         t;
   } rsp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic wr_valid, rq_valid, rs_ready;
   logic [AW-1:0] wr_addr, rq_addr, mem_rd_addr, mem_wr_addr;
   logic [7:0] wr_data, rs_data, drop_cnt, mem_rd_data, mem_wr_data;
   logic wr_ready, rq_ready, rs_valid, rs_err, mem_rd_en, mem_wr_en;
   logic [7:0] mem [0:127];
   logic [7:0] ref_mem [0:127];
   rsp_t q[$];
   int compared = 0, mismatched = 0, exp_drop = 0, cyc = 0, pops = 0;
   bit last_rd = 1'b0;

   mem_port_arbiter #(.DATA_WIDTH(8), .MAX_ADR(MA), .ADDRSIZE(AW)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
      .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data), .rs_err(rs_err),
      .drop_cnt(drop_cnt),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   initial begin
      #300000;
      $error("FAIL watchdog: simulation did not finish, cycles %0d required < 30000", cyc);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic model();
      bit pop, space, fire_w, fire_r;
      rsp_t r;
      pop   = rs_valid === 1'b1 && rs_ready;
      space = q.size() - int'(pop) < 2;
      chk("excl", 32'(mem_rd_en & mem_wr_en), 0);
      chk("one_grant", 32'(wr_ready & rq_ready), 0);
      chk("rs_valid", 32'(rs_valid), 32'(q.size() > 0 && cyc >= q[0].t + 2));
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      if (wr_valid && rq_valid && space) chk("rr", 32'({wr_ready, rq_ready}), 32'({last_rd, !last_rd}));
      else if (rq_valid && space) chk("rd_grant", 32'(rq_ready), 1);
      else if (rq_valid) chk("rd_credit", 32'(rq_ready), 0);
      if (wr_valid && !(rq_valid && space)) chk("wr_grant", 32'(wr_ready), 1);
      fire_w = wr_valid && wr_ready;
      fire_r = rq_valid && rq_ready;
      chk("mem_wr_en", 32'(mem_wr_en), 32'(fire_w && int'(wr_addr) < MA));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(fire_r && int'(rq_addr) < MA));
      if (mem_wr_en) chk("wr_pass", 32'({mem_wr_addr, mem_wr_data}), 32'({wr_addr, wr_data}));
      if (mem_rd_en) chk("rd_addr", 32'(mem_rd_addr), 32'(rq_addr));
      if (pop && q.size() > 0) begin
         r = q.pop_front();
         chk("rs_data", 32'(rs_data), 32'(r.d));
         chk("rs_err", 32'(rs_err), 32'(r.e));
         pops++;
      end
      if (fire_w) begin
         if (int'(wr_addr) < MA) ref_mem[wr_addr] = wr_data;
         else if (exp_drop < 255) exp_drop++;
      end
      if (fire_r) q.push_back('{int'(rq_addr) < MA ? ref_mem[rq_addr] : 8'h00, int'(rq_addr) >= MA, cyc});
      if (fire_w || fire_r) last_rd = fire_r;
      cyc++;
   endtask

   task automatic cycle();
      @(negedge clk);
      if (!rst) model();
      else cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
      chk("drain", 32'(q.size()), 0);
   endtask

   initial begin
      int acc, p0;
      {wr_valid, rq_valid, wr_addr, wr_data, rq_addr} = '0;
      rs_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rs", 32'({rs_valid, rs_err, rs_data}), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_strobes", 32'({mem_rd_en, mem_wr_en}), 0);
      chk("rst_ready", 32'({wr_ready, rq_ready}), 0);
      rst = 1'b0;
      for (int i = 0; i < MA; i++) begin
         wr_valid = 1'b1;
         wr_addr  = AW'(i);
         wr_data  = 8'($urandom);
         cycle();
      end
      wr_valid = 1'b0;
      // write then read back one word
      wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 8'hA5;
      #1;
      chk("t2_wr_en", 32'(mem_wr_en), 1);
      cycle();
      wr_valid = 1'b0; rq_valid = 1'b1; rq_addr = AW'(5);
      #1;
      chk("t2_rq_ready", 32'(rq_ready), 1);
      cycle();
      rq_valid = 1'b0;
      chk("t2_lat1", 32'(rs_valid), 0);
      cycle();
      chk("t2_lat2", 32'({rs_valid, rs_err, rs_data}), 32'({1'b1, 1'b0, 8'hA5}));
      cycle();
      // both streams contending
      wr_valid = 1'b1; rq_valid = 1'b1; acc = 0;
      for (int i = 0; i < 6; i++) begin
         wr_addr = AW'($urandom_range(0, MA - 1));
         wr_data = 8'($urandom);
         rq_addr = AW'($urandom_range(0, MA - 1));
         #1;
         acc += int'(rq_ready);
         cycle();
      end
      {wr_valid, rq_valid} = '0;
      chk("t3_rd_grants", 32'(acc), 3);
      drain();
      // backpressure
      rs_ready = 1'b0; rq_valid = 1'b1; acc = 0;
      for (int i = 0; i < 6; i++) begin
         rq_addr = AW'($urandom_range(0, MA - 1));
         #1;
         acc += int'(rq_ready);
         cycle();
      end
      chk("t4_accepted", 32'(acc), 2);
      chk("t4_blocked", 32'(rq_ready), 0);
      rs_ready = 1'b1;
      for (int i = 0; i < 20 && acc < 4; i++) begin
         rq_addr = AW'($urandom_range(0, MA - 1));
         #1;
         acc += int'(rq_ready);
         cycle();
      end
      rq_valid = 1'b0;
      chk("t4_total", 32'(acc), 4);
      drain();
      // streaming reads 0..9
      p0 = pops; rq_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rq_addr = AW'(i);
         #1;
         chk("t6_rq_ready", 32'(rq_ready), 1);
         cycle();
      end
      rq_valid = 1'b0;
      drain();
      chk("t6_responses", 32'(pops - p0), 10);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = AW'($urandom_range(0, 9) == 0 ? $urandom_range(MA, 127) : $urandom_range(0, MA - 1));
         wr_data  = 8'($urandom);
         rq_valid = 1'($urandom_range(0, 1));
         rq_addr  = AW'($urandom_range(0, 9) == 0 ? $urandom_range(MA, 127) : $urandom_range(0, MA - 1));
         rs_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      {wr_valid, rq_valid} = '0;
      rs_ready = 1'b1;
      drain();
      // reset with a read in flight
      rq_valid = 1'b1; rq_addr = AW'(3);
      #1;
      chk("t1_pre_fire", 32'(rq_ready), 1);
      cycle();
      rq_valid = 1'b0; wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 8'h3C;
      rst = 1'b1;
      #1;
      chk("t1_rs_valid", 32'(rs_valid), 0);
      chk("t1_drop", 32'(drop_cnt), 0);
      chk("t1_strobes", 32'({mem_rd_en, mem_wr_en}), 0);
      chk("t1_ready", 32'({wr_ready, rq_ready}), 0);
      q.delete();
      exp_drop = 0;
      last_rd = 1'b0;
      repeat (2) cycle();
      rst = 1'b0; wr_valid = 1'b0; rq_valid = 1'b1; rq_addr = AW'(8);
      #1;
      chk("t1_first_grant", 32'(rq_ready), 1);
      cycle();
      rq_valid = 1'b0;
      p0 = pops;
      repeat (5) cycle();
      chk("t1_one_rsp", 32'(pops - p0), 1);
      // out-of-range accesses
      wr_valid = 1'b1; wr_addr = AW'(100); wr_data = 8'h11;
      #1;
      chk("t5_no_wr", 32'(mem_wr_en), 0);
      cycle();
      wr_valid = 1'b0;
      chk("t5_drop1", 32'(drop_cnt), 1);
      rq_valid = 1'b1; rq_addr = AW'(127);
      cycle();
      rq_valid = 1'b0;
      cycle();
      chk("t5_err", 32'({rs_valid, rs_err, rs_data}), 32'({1'b1, 1'b1, 8'h00}));
      cycle();
      wr_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wr_addr = AW'($urandom_range(MA, 127));
         cycle();
      end
      wr_valid = 1'b0;
      chk("t5_sat", 32'(drop_cnt), 255);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
